// File: rtl/alu_issue_ctrl.sv
// Issue stage for the 8-bit combinational ALU: op FIFO, settle-window sequencer, result return.
// Optional ALU_FLAGS_EN adds registered out_zero/out_neg result flags.

// Generic synchronous FIFO, power-of-2 depth, first-word fall-through read.
// Latency: a write is visible on rd_dat/rd_vld the cycle after it is accepted.
// Backpressure: wr_rdy drops only when full; a pop in the same cycle does not free a slot for the push.
module alu_issue_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    output logic         wr_rdy,
    input  logic [W-1:0] wr_dat,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_wr;
    logic          do_rd;

    assign wr_rdy = (count != FULL_CNT);
    assign rd_vld = (count != '0);
    assign rd_dat = mem[rptr];
    assign do_wr  = wr_vld && wr_rdy;
    assign do_rd  = rd_vld && rd_rdy;

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= wr_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Buffers ops, drives them to the ALU one at a time and returns the registered result.
// Latency: op accepted at edge T (empty FIFO, idle) -> out_valid after edge T+1+SETTLE_CYC.
// Backpressure: in_ready = FIFO not full; a stalled result (out_ready low) holds the sequencer in DONE.
module alu_issue_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic [3:0] in_sel,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_sel,
    input  logic [7:0] alu_z,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_z,
    output logic       out_err
`ifdef ALU_FLAGS_EN
    ,
    output logic       out_zero,
    output logic       out_neg
`endif
);
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
    } op_t;

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(SETTLE_CYC - 1);
    localparam logic [3:0] SEL_ILLEGAL = 4'b1111;

    state_t        state;
    logic [CW-1:0] cnt;
    op_t           in_op;
    op_t           q_dat;
    logic          q_vld;
    logic          q_pop;

    assign in_op = '{a: in_a, b: in_b, sel: in_sel};
    assign q_pop = (state == IDLE);

    alu_issue_fifo #(.W($bits(op_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (in_valid),
        .wr_rdy (in_ready),
        .wr_dat (in_op),
        .rd_vld (q_vld),
        .rd_rdy (q_pop),
        .rd_dat (q_dat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            out_z     <= '0;
            out_err   <= 1'b0;
            out_valid <= 1'b0;
`ifdef ALU_FLAGS_EN
            out_zero  <= 1'b0;
            out_neg   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (q_vld) begin
                        alu_a   <= q_dat.a;
                        alu_b   <= q_dat.b;
                        alu_sel <= q_dat.sel;
                        cnt     <= '0;
                        state   <= SETTLE;
                    end
                end
                SETTLE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // The illegal opcode never reaches the result path, whatever the ALU drives.
                        if (alu_sel == SEL_ILLEGAL) begin
                            out_z   <= 8'h00;
                            out_err <= 1'b1;
`ifdef ALU_FLAGS_EN
                            out_zero <= 1'b1;
                            out_neg  <= 1'b0;
`endif
                        end else begin
                            out_z   <= alu_z;
                            out_err <= 1'b0;
`ifdef ALU_FLAGS_EN
                            out_zero <= (alu_z == 8'h00);
                            out_neg  <= alu_z[7];
`endif
                        end
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU on the alu_* port.
module tb_alu_issue_ctrl;
    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [3:0] in_sel;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_sel;
    logic [7:0] alu_z;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_z;
    logic       out_err;
`ifdef ALU_FLAGS_EN
    logic       out_zero;
    logic       out_neg;
`endif

    int checks = 0;
    int errors = 0;

    alu_issue_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sel    (in_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_z     (alu_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_err   (out_err)
`ifdef ALU_FLAGS_EN
        ,
        .out_zero  (out_zero),
        .out_neg   (out_neg)
`endif
    );

    always #5 clk = ~clk;

    // Reference ALU: add, sub, mul(low byte), shift-left; 1111 returns junk that must be ignored.
    always_comb begin
        case (alu_sel)
            4'b0000: alu_z = alu_a + alu_b;
            4'b0001: alu_z = alu_a - alu_b;
            4'b0011: alu_z = alu_a * alu_b;
            4'b1011: alu_z = alu_a << 1;
            4'b1111: alu_z = 8'h5A;
            default: alu_z = alu_a ^ alu_b;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
        in_a = a; in_b = b; in_sel = s; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_a = 8'($urandom); in_b = 8'($urandom); in_sel = 4'($urandom);
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (out_valid) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if ({alu_a, alu_b, alu_sel} !== 20'h0) begin errors++; $display("FAIL reset_alu: got %h expected 0", {alu_a, alu_b, alu_sel}); end
        checks++; if ({out_z, out_err} !== 9'h0) begin errors++; $display("FAIL reset_out: got %h expected 0", {out_z, out_err}); end
`ifdef ALU_FLAGS_EN
        checks++; if ({out_zero, out_neg} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {out_zero, out_neg}); end
`endif
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        push_op(8'h05, 8'h03, 4'b0000);           // edge T
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_T: got %b expected 0", out_valid); end
        tick();                                    // edge T+1: popped into ALU regs
        checks++; if ({alu_a, alu_b, alu_sel} !== {8'h05, 8'h03, 4'h0}) begin errors++; $display("FAIL basic_alu_load: got %h expected 05030", {alu_a, alu_b, alu_sel}); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_T1: got %b expected 0", out_valid); end
        tick();                                    // edge T+2: result captured
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: got %b expected 1", out_valid); end
        checks++; if (out_z !== 8'h08) begin errors++; $display("FAIL basic_z: got %h expected 08", out_z); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", out_err); end
        tick();                                    // edge T+3: consumed
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_consume: got %b expected 0", out_valid); end
    endtask

    task automatic test_ops();
        bit ok;
        out_ready = 1'b1;
        push_op(8'd10, 8'd20, 4'b0011);
        wait_valid(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mul_timeout: got no out_valid expected within 10 cycles"); end
        checks++; if (out_z !== 8'hC8) begin errors++; $display("FAIL mul_z: got %h expected c8", out_z); end
        tick();
        push_op(8'h81, 8'h00, 4'b1011);
        wait_valid(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL shl_timeout: got no out_valid expected within 10 cycles"); end
        checks++; if (out_z !== 8'h02) begin errors++; $display("FAIL shl_z: got %h expected 02", out_z); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] ta [7];
        logic [7:0] tb [7];
        logic [3:0] ts [7];
        logic [7:0] exp_z [5];
        int  accepted;
        bit  ok;
        ta = '{8'h01, 8'h11, 8'h21, 8'h31, 8'h41, 8'h51, 8'h61};
        tb = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        ts = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0011, 4'b0000, 4'b0000};
        exp_z = '{8'h03, 8'h14, 8'h1D, 8'h36, 8'h86};
        out_ready = 1'b0;
        accepted = 0;
        for (int k = 0; k < 7; k++) begin
            in_a = ta[k]; in_b = tb[k]; in_sel = ts[k]; in_valid = 1'b1;
            if (in_ready) accepted++;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (accepted !== 5) begin errors++; $display("FAIL b2b_accepted: got %0d expected 5", accepted); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: got %b expected 0", in_ready); end
        for (int s = 0; s < 3; s++) begin
            checks++; if ({out_valid, out_z} !== {1'b1, exp_z[0]}) begin errors++; $display("FAIL b2b_stall_%0d: got %b/%h expected 1/%h", s, out_valid, out_z, exp_z[0]); end
            tick();
        end
        out_ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            wait_valid(10, ok);
            checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout_%0d: got no out_valid expected within 10 cycles", r); end
            checks++; if (out_z !== exp_z[r]) begin errors++; $display("FAIL b2b_order_%0d: got %h expected %h", r, out_z, exp_z[r]); end
            tick();
        end
        for (int s = 0; s < 6; s++) tick();
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL b2b_drained: got %b expected 01", {out_valid, in_ready}); end
    endtask

    task automatic test_illegal();
        bit ok;
        out_ready = 1'b1;
        push_op(8'hAA, 8'h55, 4'b1111);
        wait_valid(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL illegal_timeout: got no out_valid expected within 10 cycles"); end
        checks++; if ({out_z, out_err} !== {8'h00, 1'b1}) begin errors++; $display("FAIL illegal_result: got %h/%b expected 00/1", out_z, out_err); end
`ifdef ALU_FLAGS_EN
        checks++; if ({out_zero, out_neg} !== 2'b10) begin errors++; $display("FAIL illegal_flags: got %b expected 10", {out_zero, out_neg}); end
`endif
        tick();
        push_op(8'h01, 8'h01, 4'b0000);
        wait_valid(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL legal_after_timeout: got no out_valid expected within 10 cycles"); end
        checks++; if ({out_z, out_err} !== {8'h02, 1'b0}) begin errors++; $display("FAIL legal_after_illegal: got %h/%b expected 02/0", out_z, out_err); end
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int stale;
        out_ready = 1'b0;
        push_op(8'h10, 8'h01, 4'b0000);
        push_op(8'h20, 8'h02, 4'b0000);
        push_op(8'h30, 8'h03, 4'b0000);
        push_op(8'h40, 8'h04, 4'b0000);
        wait_valid(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout: got no out_valid expected within 10 cycles"); end
        out_ready = 1'b1;
        tick();                                    // first result consumed
        tick();                                    // second op popped, settling; two still queued
        checks++; if ({out_valid, alu_a} !== {1'b0, 8'h20}) begin errors++; $display("FAIL rstmid_settle: got %b/%h expected 0/20", out_valid, alu_a); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL rstmid_ctrl: got %b expected 01", {out_valid, in_ready}); end
        checks++; if ({alu_a, alu_b, alu_sel} !== 20'h0) begin errors++; $display("FAIL rstmid_alu: got %h expected 0", {alu_a, alu_b, alu_sel}); end
        stale = 0;
        for (int s = 0; s < 10; s++) begin
            if (out_valid) stale++;
            tick();
        end
        checks++; if (stale !== 0) begin errors++; $display("FAIL rstmid_stale: got %0d valid cycles expected 0", stale); end
        push_op(8'h07, 8'h02, 4'b0001);
        wait_valid(10, ok);
        checks++; if ({ok, out_z} !== {1'b1, 8'h05}) begin errors++; $display("FAIL rstmid_recover: got %b/%h expected 1/05", ok, out_z); end
        tick();
    endtask

    task automatic test_flags();
        bit ok;
        out_ready = 1'b1;
        push_op(8'd3, 8'd3, 4'b0001);
        wait_valid(10, ok);
        checks++; if ({ok, out_z} !== {1'b1, 8'h00}) begin errors++; $display("FAIL sub_zero_z: got %b/%h expected 1/00", ok, out_z); end
`ifdef ALU_FLAGS_EN
        checks++; if ({out_zero, out_neg} !== 2'b10) begin errors++; $display("FAIL sub_zero_flags: got %b expected 10", {out_zero, out_neg}); end
`endif
        tick();
        push_op(8'd1, 8'd2, 4'b0001);
        wait_valid(10, ok);
        checks++; if ({ok, out_z} !== {1'b1, 8'hFF}) begin errors++; $display("FAIL sub_neg_z: got %b/%h expected 1/ff", ok, out_z); end
`ifdef ALU_FLAGS_EN
        checks++; if ({out_zero, out_neg} !== 2'b01) begin errors++; $display("FAIL sub_neg_flags: got %b expected 01", {out_zero, out_neg}); end
`endif
        tick();
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_sel = '0;
        test_reset();
        test_basic();
        test_ops();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        test_flags();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
